// File: rtl/contador_pulsos_param.sv
// Debounced push-button rising-edge counter with configurable width,
// up/down direction and a wrap-or-saturate policy at the count limits.
module contador_pulsos_param #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boton,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             pulse,
  output logic             wrap,
  output logic             boton_db
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic             sync1;
  logic             s;
  logic [DW-1:0]    deb_cnt;
  logic             accept;
  logic             rise;
  logic             at_limit;
  logic [WIDTH-1:0] count_step;

  always_comb begin
    accept = (s != boton_db) && (deb_cnt == DEB_LAST);
    rise   = accept && s;
  end

  // Candidate count for an enabled step; in saturate mode a limit hit holds the value.
  always_comb begin
    at_limit   = dir ? (count == CNT_MAX) : (count == '0);
    count_step = dir ? (count + 1'b1) : (count - 1'b1);
    if (at_limit && SATURATE) begin
      count_step = count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      deb_cnt  <= '0;
      boton_db <= 1'b0;
      count    <= '0;
      pulse    <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      sync1 <= boton;
      s     <= sync1;

      // Any return of s to the accepted level restarts the persistence window.
      if (s == boton_db) begin
        deb_cnt <= '0;
      end else if (accept) begin
        boton_db <= s;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      pulse <= rise;
      wrap  <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (rise && en) begin
        count <= count_step;
        wrap  <= at_limit;
      end
    end
  end

endmodule
